tnoc_local_flit_packer: RTL and testbench

//  Transmit-side network interface for a router local input port: accepts one packet

---
 rtl/tnoc_local_flit_packer.sv | 127 ++++++++++++
 tb/tb_tnoc_local_flit_packer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tnoc_local_flit_packer.sv
// Local-port network interface: packs a packet command plus payload beats into
// head/payload/tail flits on a one-hot per-VC valid/ready flit link.
module tnoc_local_flit_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_X_WIDTH = 3,
    parameter int ID_Y_WIDTH = 3,
    parameter int CHANNELS   = 2,
    parameter int LEN_WIDTH  = 5,
    parameter int TAG_WIDTH  = 8,
    localparam int VC_WIDTH  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_X_WIDTH-1:0]   i_id_x,
    input  logic [ID_Y_WIDTH-1:0]   i_id_y,
    input  logic                    i_pkt_valid,
    output logic                    o_pkt_ready,
    input  logic [ID_X_WIDTH-1:0]   i_dst_x,
    input  logic [ID_Y_WIDTH-1:0]   i_dst_y,
    input  logic [VC_WIDTH-1:0]     i_vc,
    input  logic [TAG_WIDTH-1:0]    i_tag,
    input  logic [LEN_WIDTH-1:0]    i_len,
    input  logic                    i_pay_valid,
    output logic                    o_pay_ready,
    input  logic [DATA_WIDTH-1:0]   i_pay_data,
    input  logic                    i_pay_last,
    output logic [CHANNELS-1:0]     o_flit_valid,
    input  logic [CHANNELS-1:0]     i_flit_ready,
    output logic [DATA_WIDTH+1:0]   o_flit,
    output logic                    o_err,
    output logic [15:0]             o_pkt_count
);

    localparam int HDR_WIDTH = 2*ID_X_WIDTH + 2*ID_Y_WIDTH + VC_WIDTH + TAG_WIDTH + LEN_WIDTH;

    generate
        if (HDR_WIDTH > DATA_WIDTH) begin : g_hdr_check
            $error("tnoc_local_flit_packer: header fields do not fit in DATA_WIDTH");
        end
    endgenerate

    typedef enum logic {IDLE, PAYLOAD} state_t;

    state_t                 state;
    logic [VC_WIDTH-1:0]    pkt_vc;
    logic [LEN_WIDTH-1:0]   beat_cnt;
    logic                   slot_busy;
    logic                   slot_drain;
    logic                   slot_free;
    logic                   cmd_fire;
    logic                   beat_fire;
    logic                   vc_bad;
    logic                   tail_beat;
    logic [VC_WIDTH-1:0]    accept_vc;
    logic [DATA_WIDTH-1:0]  head_data;

    function automatic logic [CHANNELS-1:0] vc_onehot(input logic [VC_WIDTH-1:0] vc);
        vc_onehot = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (vc == VC_WIDTH'(c)) vc_onehot[c] = 1'b1;
        end
    endfunction

    // Only encodings beyond CHANNELS-1 can be out of range; skip the compare
    // when the VC field cannot express one.
    generate
        if ((2 ** VC_WIDTH) > CHANNELS) begin : g_vc_range
            assign vc_bad = (i_vc > VC_WIDTH'(CHANNELS - 1));
        end else begin : g_vc_full
            assign vc_bad = 1'b0;
        end
    endgenerate

    // Valid is one-hot, so any matching ready means the held flit leaves now.
    assign slot_busy  = |o_flit_valid;
    assign slot_drain = |(o_flit_valid & i_flit_ready);
    assign slot_free  = !slot_busy || slot_drain;

    assign o_pkt_ready = !rst && (state == IDLE)    && slot_free;
    assign o_pay_ready = !rst && (state == PAYLOAD) && slot_free;

    assign cmd_fire  = i_pkt_valid && o_pkt_ready;
    assign beat_fire = i_pay_valid && o_pay_ready;
    assign tail_beat = (beat_cnt == LEN_WIDTH'(1));
    assign accept_vc = vc_bad ? '0 : i_vc;
    assign head_data = DATA_WIDTH'({i_len, i_tag, accept_vc, i_id_y, i_id_x, i_dst_y, i_dst_x});

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            o_flit_valid <= '0;
            o_flit       <= '0;
            o_err        <= 1'b0;
            o_pkt_count  <= '0;
            beat_cnt     <= '0;
            pkt_vc       <= '0;
        end else begin
            if (slot_drain) begin
                o_flit_valid <= '0;
                if (o_flit[DATA_WIDTH]) o_pkt_count <= o_pkt_count + 16'd1;
            end
            unique case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        o_flit_valid <= vc_onehot(accept_vc);
                        o_flit       <= {1'b1, (i_len == '0), head_data};
                        pkt_vc       <= accept_vc;
                        beat_cnt     <= i_len;
                        if (vc_bad) o_err <= 1'b1;
                        if (i_len != '0) state <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (beat_fire) begin
                        o_flit_valid <= vc_onehot(pkt_vc);
                        o_flit       <= {1'b0, tail_beat, i_pay_data};
                        beat_cnt     <= beat_cnt - 1'b1;
                        if (i_pay_last != tail_beat) o_err <= 1'b1;
                        if (tail_beat) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tnoc_local_flit_packer.sv
// Directed bench for tnoc_local_flit_packer: transaction-level model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_tnoc_local_flit_packer;

    localparam int DW  = 32;
    localparam int XW  = 3;
    localparam int YW  = 3;
    localparam int CH  = 3;
    localparam int LW  = 5;
    localparam int TW  = 8;
    localparam int VCW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [XW-1:0]   i_id_x;
    logic [YW-1:0]   i_id_y;
    logic            i_pkt_valid;
    logic            o_pkt_ready;
    logic [XW-1:0]   i_dst_x;
    logic [YW-1:0]   i_dst_y;
    logic [VCW-1:0]  i_vc;
    logic [TW-1:0]   i_tag;
    logic [LW-1:0]   i_len;
    logic            i_pay_valid;
    logic            o_pay_ready;
    logic [DW-1:0]   i_pay_data;
    logic            i_pay_last;
    logic [CH-1:0]   o_flit_valid;
    logic [CH-1:0]   i_flit_ready;
    logic [DW+1:0]   o_flit;
    logic            o_err;
    logic [15:0]     o_pkt_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    tnoc_local_flit_packer #(
        .DATA_WIDTH(DW), .ID_X_WIDTH(XW), .ID_Y_WIDTH(YW),
        .CHANNELS(CH), .LEN_WIDTH(LW), .TAG_WIDTH(TW)
    ) dut (
        .clk(clk), .rst(rst), .i_id_x(i_id_x), .i_id_y(i_id_y),
        .i_pkt_valid(i_pkt_valid), .o_pkt_ready(o_pkt_ready),
        .i_dst_x(i_dst_x), .i_dst_y(i_dst_y), .i_vc(i_vc), .i_tag(i_tag), .i_len(i_len),
        .i_pay_valid(i_pay_valid), .o_pay_ready(o_pay_ready),
        .i_pay_data(i_pay_data), .i_pay_last(i_pay_last),
        .o_flit_valid(o_flit_valid), .i_flit_ready(i_flit_ready), .o_flit(o_flit),
        .o_err(o_err), .o_pkt_count(o_pkt_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void timeout(string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endfunction

    function automatic logic [DW+1:0] hdr_flit(int dx, int dy, int sx, int sy, int vc, int tag, int len);
        longint d;
        d = longint'(dx) + (longint'(dy) << 3) + (longint'(sx) << 6) + (longint'(sy) << 9)
          + (longint'(vc) << 12) + (longint'(tag) << (12 + VCW)) + (longint'(len) << (20 + VCW));
        return {1'b1, (len == 0), d[DW-1:0]};
    endfunction

    // Model: one output slot, remaining payload beats of the open packet, sticky error, count.
    bit              m_init = 0;
    bit              m_sv = 0;
    logic [DW+1:0]   m_sflit = '0;
    int              m_svc = 0;
    int              m_pvc = 0;
    int              m_rem = 0;
    bit              m_err = 0;
    logic [15:0]     m_cnt = '0;
    bit              m_drained;
    bit              m_free;
    bit              m_pkt_rdy;
    bit              m_pay_rdy;
    bit              m_bad;
    bit              m_last;
    logic [CH-1:0]   m_ev;
    logic [DW+1:0]   flit_log[$];
    int              cyc_log[$];

    always @(negedge clk) begin
        m_drained = m_sv && i_flit_ready[m_svc];
        m_free    = !m_sv || m_drained;
        m_pkt_rdy = !rst && (m_rem == 0) && m_free;
        m_pay_rdy = !rst && (m_rem > 0) && m_free;
        m_ev      = m_sv ? CH'(1 << m_svc) : '0;
        if (m_init) begin
            check("flit_valid", o_flit_valid, m_ev);
            if (m_sv) check("flit", o_flit, m_sflit);
            check("pkt_ready", o_pkt_ready, m_pkt_rdy);
            check("pay_ready", o_pay_ready, m_pay_rdy);
            check("err", o_err, m_err);
            check("pkt_count", o_pkt_count, m_cnt);
        end
        if (rst) begin
            m_init = 1; m_sv = 0; m_sflit = '0; m_svc = 0; m_pvc = 0;
            m_rem = 0; m_err = 0; m_cnt = '0;
        end else if (m_init) begin
            if (m_drained) begin
                flit_log.push_back(m_sflit);
                cyc_log.push_back(cyc);
                if (m_sflit[DW]) m_cnt = m_cnt + 16'd1;
                m_sv = 0;
            end
            if (m_pkt_rdy && i_pkt_valid) begin
                m_bad = int'(i_vc) >= CH;
                if (m_bad) m_err = 1;
                m_pvc   = m_bad ? 0 : int'(i_vc);
                m_sflit = hdr_flit(int'(i_dst_x), int'(i_dst_y), int'(i_id_x), int'(i_id_y),
                                   m_pvc, int'(i_tag), int'(i_len));
                m_sv  = 1;
                m_svc = m_pvc;
                m_rem = int'(i_len);
            end else if (m_pay_rdy && i_pay_valid) begin
                m_last = (m_rem == 1);
                if (i_pay_last != m_last) m_err = 1;
                m_sflit = {1'b0, m_last, i_pay_data};
                m_sv  = 1;
                m_svc = m_pvc;
                m_rem = m_rem - 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input int dx, input int dy, input int vc, input int tag, input int len);
        bit hs;
        bit done;
        done = 0;
        i_pkt_valid = 1'b1;
        i_dst_x = XW'(dx); i_dst_y = YW'(dy); i_vc = VCW'(vc); i_tag = TW'(tag); i_len = LW'(len);
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            hs = o_pkt_ready;
            tick();
            if (hs) done = 1;
        end
        i_pkt_valid = 1'b0;
        if (!done) timeout("cmd_accept");
    endtask

    task automatic send_beats(input int n, input logic [DW-1:0] base, input int last_idx);
        bit hs;
        bit done;
        for (int i = 0; i < n; i++) begin
            done = 0;
            i_pay_valid = 1'b1;
            i_pay_data  = base + DW'(i);
            i_pay_last  = (i == last_idx);
            for (int t = 0; t < 200 && !done; t++) begin
                @(negedge clk);
                hs = o_pay_ready;
                tick();
                if (hs) done = 1;
            end
            if (!done) timeout("beat_accept");
        end
        i_pay_valid = 1'b0;
        i_pay_last  = 1'b0;
    endtask

    task automatic clear_log();
        flit_log.delete();
        cyc_log.delete();
    endtask

    initial begin
        logic [DW+1:0] held;
        bit            seen;
        int            n;
        rst = 1'b1;
        i_id_x = '0; i_id_y = '0;
        i_pkt_valid = 1'b0; i_dst_x = '0; i_dst_y = '0; i_vc = '0; i_tag = '0; i_len = '0;
        i_pay_valid = 1'b0; i_pay_data = '0; i_pay_last = 1'b0;
        i_flit_ready = '1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // 1: header-only packet on VC 1, own tile (0,0)
        clear_log();
        send_cmd(2, 1, 1, 'h5A, 0);
        check("t1_valid", o_flit_valid, 3'b010);
        check("t1_flit", o_flit, 34'h3_0016_900A);
        tick(); tick();
        check("t1_count", o_pkt_count, 16'd1);
        check("t1_nflits", flit_log.size(), 1);

        // 2: three-beat packet at full throughput, own tile (5,6)
        i_id_x = 3'd5; i_id_y = 3'd6;
        clear_log();
        send_cmd(3, 4, 0, 'hC3, 3);
        send_beats(3, 32'hA000_0000, 2);
        repeat (3) tick();
        check("t2_nflits", flit_log.size(), 4);
        if (flit_log.size() == 4) begin
            check("t2_head", flit_log[0], 34'h2_00F0_CD63);
            check("t2_beat0", flit_log[1], 34'h0_A000_0000);
            check("t2_beat1", flit_log[2], 34'h0_A000_0001);
            check("t2_tail", flit_log[3], 34'h1_A000_0002);
            check("t2_span", cyc_log[3] - cyc_log[0], 3);
        end
        check("t2_err", o_err, 1'b0);

        // 3: router stalls VC 1 for four cycles on payload 1
        clear_log();
        fork
            begin
                send_cmd(1, 2, 1, 'h33, 2);
                send_beats(2, 32'h0000_00B0, 1);
            end
            begin
                seen = 0;
                for (int t = 0; t < 50 && !seen; t++) begin
                    tick();
                    if (o_flit_valid[1] && !o_flit[DW+1]) seen = 1;
                end
                if (!seen) timeout("t3_payload_wait");
                i_flit_ready = '0;
                held = o_flit;
                repeat (4) begin
                    @(negedge clk);
                    check("t3_hold", o_flit, held);
                    check("t3_pay_ready", o_pay_ready, 1'b0);
                end
                tick();
                i_flit_ready = '1;
            end
        join
        repeat (3) tick();
        check("t3_nflits", flit_log.size(), 3);
        if (flit_log.size() == 3) begin
            check("t3_beat0", flit_log[1], 34'h0_0000_00B0);
            check("t3_tail", flit_log[2], 34'h1_0000_00B1);
        end
        check("t3_err", o_err, 1'b0);

        // 4: early last marker flags an error, framing follows the length
        clear_log();
        send_cmd(6, 2, 0, 'h44, 2);
        send_beats(2, 32'h0000_0D00, 0);
        repeat (3) tick();
        check("t4_err", o_err, 1'b1);
        check("t4_nflits", flit_log.size(), 3);
        if (flit_log.size() == 3) begin
            check("t4_beat0_tail", flit_log[1][DW], 1'b0);
            check("t4_beat1_tail", flit_log[2][DW], 1'b1);
        end

        // 5: reset mid-packet, then a fresh header-only packet
        send_cmd(1, 1, 1, 'h11, 4);
        send_beats(1, 32'h0000_00C0, -1);
        rst = 1'b1;
        tick();
        check("t5_valid", o_flit_valid, 3'b000);
        check("t5_flit", o_flit, 34'h0);
        check("t5_pkt_ready", o_pkt_ready, 1'b0);
        check("t5_pay_ready", o_pay_ready, 1'b0);
        check("t5_err", o_err, 1'b0);
        check("t5_count", o_pkt_count, 16'd0);
        rst = 1'b0;
        tick();
        clear_log();
        send_cmd(7, 7, 2, 'hFF, 0);
        check("t5_new_valid", o_flit_valid, 3'b100);
        tick(); tick();
        check("t5_new_count", o_pkt_count, 16'd1);
        check("t5_new_nflits", flit_log.size(), 1);

        // 6: out-of-range VC goes out on VC 0 and sets the error
        send_cmd(0, 1, 3, 'h42, 0);
        check("t6_err", o_err, 1'b1);
        check("t6_valid", o_flit_valid, 3'b001);
        check("t6_flit", o_flit, 34'h3_0010_8D48);
        tick(); tick();

        // packet counter wrap over 65536 back-to-back header-only packets
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        i_dst_x = 3'd1; i_dst_y = 3'd0; i_vc = '0; i_tag = 8'h01; i_len = '0;
        i_pkt_valid = 1'b1;
        n = 0;
        for (int t = 0; t < 70000 && n < 65536; t++) begin
            @(negedge clk);
            if (o_pkt_ready) n++;
            tick();
        end
        i_pkt_valid = 1'b0;
        if (n < 65536) timeout("wrap_stream");
        check("wrap_before", o_pkt_count, 16'hFFFF);
        tick(); tick();
        check("wrap_after", o_pkt_count, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
